// File: rtl/frogger_pkg.sv
// Shared frogger definitions: game states, screen geometry and river lane tables.
// Used by the river lanes, the frog controller and the renderer.
package frogger_pkg;

  typedef enum logic [1:0] {
    ST_MENU    = 2'd0,
    ST_PLAYING = 2'd1,
    ST_DEAD    = 2'd2,
    ST_WIN     = 2'd3
  } game_state_t;

  localparam int SCREEN_W  = 640;
  localparam int SCREEN_H  = 480;
  localparam int BLOCKSIZE = 32;
  localparam int NUM_LANES = 6;
  localparam int RIVER_TOP = 64;
  localparam int LANE_H    = BLOCKSIZE;
  localparam int LOG_LEN   = 96;
  localparam int LOG_GAP   = 320;

  typedef logic [9:0] coord_t;
  typedef logic [6:0] log_len_t;

  // Signed pixels per frame for each lane; magnitudes stay within 31.
  function automatic int lane_speed(input int lane);
    case (lane)
      0:       return 2;
      1:       return -3;
      2:       return 1;
      3:       return -2;
      4:       return 3;
      5:       return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int lane_init_x(input int lane);
    case (lane)
      0:       return 0;
      1:       return 64;
      2:       return 128;
      3:       return 192;
      4:       return 256;
      5:       return 320;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/log_lane.sv
// One river lane: log position with wrap, two-log coverage test against the
// frog centre, row match, and the one-cycle speed pulse for the frog controller.
module log_lane
  import frogger_pkg::*;
#(
  parameter int SPEED  = 0,
  parameter int INIT_X = 0,
  parameter int LANE_Y = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        i_state,
  input  logic              i_frame_tick,
  input  logic [10:0]       i_cx,
  input  coord_t            i_frog_y,
  output coord_t            o_log_x,
  output logic signed [9:0] o_speed,
  output logic              o_in_log,
  output logic              o_row_hit,
  output logic              o_on_log
);

  localparam logic signed [10:0] SPEED_S = 11'(SPEED);
  localparam logic signed [10:0] WRAP_S  = 11'(SCREEN_W);
  localparam logic signed [10:0] LEN_S   = 11'(LOG_LEN);
  localparam logic signed [10:0] GAP_S   = 11'(LOG_GAP);
  localparam logic signed [9:0]  SPEED_V = 10'(SPEED);
  localparam coord_t             INIT_V  = 10'(INIT_X);
  localparam coord_t             ROW_LO  = 10'(LANE_Y);
  localparam coord_t             ROW_HI  = 10'(LANE_Y + LANE_H);

  coord_t              r_log_x;
  logic signed [9:0]   r_speed;
  logic                r_in_log;

  logic                w_playing;
  logic                w_advance;
  logic signed [10:0]  w_sum;
  logic signed [10:0]  w_wrap;
  logic signed [10:0]  w_d_raw;
  logic signed [10:0]  w_d;
  logic signed [10:0]  w_e_raw;
  logic signed [10:0]  w_e;
  logic                w_on_a;
  logic                w_on_b;
  logic                w_row;

  // Next log position and coverage test, both taken from the pre-update log_x.
  always_comb begin
    w_playing = (i_state == ST_PLAYING);
    w_advance = w_playing && i_frame_tick;

    w_sum = $signed({1'b0, r_log_x}) + SPEED_S;
    if (w_sum >= WRAP_S) begin
      w_wrap = w_sum - WRAP_S;
    end else if (w_sum < 11'sd0) begin
      w_wrap = w_sum + WRAP_S;
    end else begin
      w_wrap = w_sum;
    end

    w_d_raw = $signed(i_cx - {1'b0, r_log_x});
    if (w_d_raw < 11'sd0) begin
      w_d = w_d_raw + WRAP_S;
    end else begin
      w_d = w_d_raw;
    end

    // Log B trails log A by LOG_GAP, so its distance is d shifted by the gap.
    w_e_raw = w_d - GAP_S;
    if (w_e_raw < 11'sd0) begin
      w_e = w_e_raw + WRAP_S;
    end else begin
      w_e = w_e_raw;
    end

    w_on_a = (w_d < LEN_S);
    w_on_b = (w_e < LEN_S);
    w_row  = (i_frog_y >= ROW_LO) && (i_frog_y < ROW_HI);
  end

  // Position register, speed pulse and riding flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_log_x  <= INIT_V;
      r_speed  <= 10'sd0;
      r_in_log <= 1'b0;
    end else begin
      case (i_state)
        ST_MENU:    r_log_x <= INIT_V;
        ST_PLAYING: r_log_x <= i_frame_tick ? 10'(w_wrap) : r_log_x;
        default:    r_log_x <= r_log_x;
      endcase
      r_speed  <= w_advance ? SPEED_V : 10'sd0;
      r_in_log <= w_playing && w_row && (w_on_a || w_on_b);
    end
  end

  assign o_log_x   = r_log_x;
  assign o_speed   = r_speed;
  assign o_in_log  = r_in_log;
  assign o_row_hit = w_row;
  assign o_on_log  = w_on_a || w_on_b;

endmodule

// File: rtl/river_lanes.sv
// River section for the frog controller: six log lanes, drowning detect and
// flattened log positions for the renderer.
module river_lanes
  import frogger_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        state,
  input  logic              frame_tick,
  input  logic [9:0]        frog_x,
  input  logic [9:0]        frog_y,
  input  logic [9:0]        frog_size,
  output logic signed [9:0] lane0_log_speed,
  output logic signed [9:0] lane1_log_speed,
  output logic signed [9:0] lane2_log_speed,
  output logic signed [9:0] lane3_log_speed,
  output logic signed [9:0] lane4_log_speed,
  output logic signed [9:0] lane5_log_speed,
  output logic              in_lane0_log,
  output logic              in_lane1_log,
  output logic              in_lane2_log,
  output logic              in_lane3_log,
  output logic              in_lane4_log,
  output logic              in_lane5_log,
  output logic              drowned,
  output logic [59:0]       log_x_flat
);

  logic [10:0]                w_cx;
  coord_t                     w_log_x [NUM_LANES];
  logic signed [9:0]          w_speed [NUM_LANES];
  logic [NUM_LANES-1:0]       w_in_log;
  logic [NUM_LANES-1:0]       w_row_hit;
  logic [NUM_LANES-1:0]       w_on_log;
  logic                       w_drown_next;
  logic                       r_drowned;

  assign w_cx = 11'(frog_x) + 11'(frog_size >> 1);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    log_lane #(
      .SPEED  (lane_speed(g)),
      .INIT_X (lane_init_x(g)),
      .LANE_Y (RIVER_TOP + LANE_H * g)
    ) u_lane (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_state      (state),
      .i_frame_tick (frame_tick),
      .i_cx         (w_cx),
      .i_frog_y     (frog_y),
      .o_log_x      (w_log_x[g]),
      .o_speed      (w_speed[g]),
      .o_in_log     (w_in_log[g]),
      .o_row_hit    (w_row_hit[g]),
      .o_on_log     (w_on_log[g])
    );
    assign log_x_flat[10*g +: 10] = w_log_x[g];
  end

  // Lanes are contiguous, so any row hit means the frog is over the river.
  always_comb begin
    w_drown_next = (state == ST_PLAYING) && (|w_row_hit) && !(|(w_row_hit & w_on_log));
  end

  // Drowning flag, evaluated alongside the per-lane riding flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_drowned <= 1'b0;
    end else begin
      r_drowned <= w_drown_next;
    end
  end

  assign drowned         = r_drowned;
  assign lane0_log_speed = w_speed[0];
  assign lane1_log_speed = w_speed[1];
  assign lane2_log_speed = w_speed[2];
  assign lane3_log_speed = w_speed[3];
  assign lane4_log_speed = w_speed[4];
  assign lane5_log_speed = w_speed[5];
  assign in_lane0_log    = w_in_log[0];
  assign in_lane1_log    = w_in_log[1];
  assign in_lane2_log    = w_in_log[2];
  assign in_lane3_log    = w_in_log[3];
  assign in_lane4_log    = w_in_log[4];
  assign in_lane5_log    = w_in_log[5];

endmodule

// File: tb/tb_river_lanes.sv
// Directed bench for river_lanes: riding vector table plus hand sequences for
// reset, log advance/wrap, speed pulse, state-exit tick and async reset.
module tb_river_lanes;

  logic              clk;
  logic              reset_n;
  logic [1:0]        state;
  logic              frame_tick;
  logic [9:0]        frog_x;
  logic [9:0]        frog_y;
  logic [9:0]        frog_size;
  logic signed [9:0] sp0, sp1, sp2, sp3, sp4, sp5;
  logic              il0, il1, il2, il3, il4, il5;
  logic              drowned;
  logic [59:0]       log_x_flat;

  int n_vec;
  int n_bad;

  typedef struct {
    logic [1:0] st;
    int         fx;
    int         fy;
    int         fs;
    logic [5:0] in_exp;
    logic       dr_exp;
  } vec_t;

  vec_t vt [22];

  int init_x [6] = '{0, 64, 128, 192, 256, 320};
  int speed  [6] = '{2, -3, 1, -2, 3, -1};

  river_lanes dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .state           (state),
    .frame_tick      (frame_tick),
    .frog_x          (frog_x),
    .frog_y          (frog_y),
    .frog_size       (frog_size),
    .lane0_log_speed (sp0),
    .lane1_log_speed (sp1),
    .lane2_log_speed (sp2),
    .lane3_log_speed (sp3),
    .lane4_log_speed (sp4),
    .lane5_log_speed (sp5),
    .in_lane0_log    (il0),
    .in_lane1_log    (il1),
    .in_lane2_log    (il2),
    .in_lane3_log    (il3),
    .in_lane4_log    (il4),
    .in_lane5_log    (il5),
    .drowned         (drowned),
    .log_x_flat      (log_x_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int get_speed(input int i);
    case (i)
      0:       return int'(sp0);
      1:       return int'(sp1);
      2:       return int'(sp2);
      3:       return int'(sp3);
      4:       return int'(sp4);
      default: return int'(sp5);
    endcase
  endfunction

  function automatic int get_log(input int i);
    logic [9:0] v;
    v = log_x_flat[10*i +: 10];
    return int'(v);
  endfunction

  function automatic int get_in();
    return int'({il5, il4, il3, il2, il1, il0});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic chk_speeds_zero(input string nm);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_speed%0d", nm, i), get_speed(i), 0);
  endtask

  task automatic chk_logs_init(input string nm);
    for (int i = 0; i < 6; i++) chk($sformatf("%s_log%0d", nm, i), get_log(i), init_x[i]);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    vt[0]  = '{2'd1, 16,  64,  32, 6'b000001, 1'b0};
    vt[1]  = '{2'd1, 100, 64,  32, 6'b000000, 1'b1};
    vt[2]  = '{2'd1, 330, 64,  32, 6'b000001, 1'b0};
    vt[3]  = '{2'd1, 79,  64,  32, 6'b000001, 1'b0};
    vt[4]  = '{2'd1, 80,  64,  32, 6'b000000, 1'b1};
    vt[5]  = '{2'd1, 48,  96,  32, 6'b000010, 1'b0};
    vt[6]  = '{2'd1, 47,  127, 32, 6'b000000, 1'b1};
    vt[7]  = '{2'd1, 0,   224, 32, 6'b100000, 1'b0};
    vt[8]  = '{2'd1, 200, 255, 32, 6'b000000, 1'b1};
    vt[9]  = '{2'd1, 16,  256, 32, 6'b000000, 1'b0};
    vt[10] = '{2'd1, 16,  63,  32, 6'b000000, 1'b0};
    vt[11] = '{2'd1, 0,   64,  0,  6'b000001, 1'b0};
    vt[12] = '{2'd1, 79,  64,  33, 6'b000001, 1'b0};
    vt[13] = '{2'd1, 79,  64,  35, 6'b000000, 1'b1};
    vt[14] = '{2'd0, 16,  64,  32, 6'b000000, 1'b0};
    vt[15] = '{2'd2, 100, 64,  32, 6'b000000, 1'b0};
    vt[16] = '{2'd3, 16,  64,  32, 6'b000000, 1'b0};
    vt[17] = '{2'd1, 16,  64,  32, 6'b000001, 1'b0};
    vt[18] = '{2'd1, 500, 200, 32, 6'b000000, 1'b1};
    vt[19] = '{2'd1, 604, 200, 32, 6'b010000, 1'b0};
    vt[20] = '{2'd1, 184, 160, 32, 6'b001000, 1'b0};
    vt[21] = '{2'd1, 0,   192, 20, 6'b010000, 1'b0};

    reset_n    = 1'b0;
    state      = 2'd0;
    frame_tick = 1'b0;
    frog_x     = 10'd0;
    frog_y     = 10'd0;
    frog_size  = 10'd32;
    #12;
    chk_logs_init("reset");
    chk_speeds_zero("reset");
    chk("reset_in", get_in(), 0);
    chk("reset_drowned", int'(drowned), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // MENU holds logs at their start positions and never pulses speed.
    for (int t = 0; t < 10; t++) begin
      do_tick();
      chk_speeds_zero($sformatf("menu%0d", t));
    end
    chk_logs_init("menu");

    // Advance from aligned start; checkpoints cover the pulse and both wraps.
    state = 2'd1;
    for (int k = 1; k <= 555; k++) begin
      do_tick();
      if (k == 1) begin
        for (int i = 0; i < 6; i++) chk($sformatf("pulse_speed%0d", i), get_speed(i), speed[i]);
        chk("tick1_log0", get_log(0), 2);
        chk("tick1_log1", get_log(1), 61);
        step();
        chk_speeds_zero("pulse_end");
      end
      if (k == 21) chk("wrap_l1_pre", get_log(1), 1);
      if (k == 22) chk("wrap_l1_neg", get_log(1), 638);
      if (k == 472) begin
        chk("l2_at_600", get_log(2), 600);
        frog_y = 10'd128;
        frog_x = 10'd4;
        step();
        chk("l2_logA_wrap", get_in(), 6'b000100);
        frog_x = 10'd324;
        step();
        chk("l2_logB", get_in(), 6'b000100);
        frog_y = 10'd0;
      end
      if (k == 554) chk("wrap_l4_pre", get_log(4), 638);
      if (k == 555) chk("wrap_l4_pos", get_log(4), 1);
      if (k == 1 || k == 22 || k == 472 || k == 555) begin
        for (int i = 0; i < 6; i++)
          chk($sformatf("k%0d_log%0d", k, i), get_log(i), (((init_x[i] + speed[i] * k) % 640) + 640) % 640);
      end
    end

    // Riding table against start-aligned logs; no ticks so logs stay put.
    state = 2'd0;
    step();
    chk_logs_init("realign");
    for (int v = 0; v < 22; v++) begin
      state     = vt[v].st;
      frog_x    = 10'(vt[v].fx);
      frog_y    = 10'(vt[v].fy);
      frog_size = 10'(vt[v].fs);
      step();
      chk($sformatf("vec%0d_in", v), get_in(), int'(vt[v].in_exp));
      chk($sformatf("vec%0d_drowned", v), int'(drowned), int'(vt[v].dr_exp));
    end

    // Tick on the cycle the game leaves PLAYING: no move, no pulse, flags clear.
    state     = 2'd1;
    frog_x    = 10'd16;
    frog_y    = 10'd64;
    frog_size = 10'd32;
    step();
    chk("pre_dead_in", get_in(), 1);
    state = 2'd2;
    do_tick();
    chk_speeds_zero("dead_tick");
    chk_logs_init("dead_tick");
    chk("dead_in", get_in(), 0);
    chk("dead_drowned", int'(drowned), 0);

    // Pulse and riding flag share the pre-tick log; then reset mid-pulse.
    state = 2'd0;
    step();
    state = 2'd1;
    step();
    do_tick();
    chk("same_cycle_speed0", get_speed(0), 2);
    chk("same_cycle_in", get_in(), 1);
    chk("same_cycle_log0", get_log(0), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk_speeds_zero("async_rst");
    chk_logs_init("async_rst");
    chk("async_rst_in", get_in(), 0);
    chk("async_rst_drowned", int'(drowned), 0);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/river_lanes.md
Name: river_lanes

Overview:
Upstream feeder for the frog controller. Owns the six river lanes: it advances two logs per lane on each frame tick, and tells the frog controller when a ride is due and by how much (`laneN_log_speed` plus `in_laneN_log`). It also flags drowning as a collision source and exports log positions to the renderer. Only live in the PLAYING game state.

Parameters:
- RIVER_TOP, 64: y of the top edge of lane 0. Lane i spans [RIVER_TOP+32*i, RIVER_TOP+32*i+LANE_H).
- LANE_H, 32: lane height in pixels. Equals the frog step.
- LOG_LEN, 96: log length in pixels.
- LOG_GAP, 320: x offset of the second log in each lane relative to the first.
- SCREEN_W, 640: horizontal wrap modulus.
- LANE_SPEED[0:5], {2,-3,1,-2,3,-1}: signed pixels per frame. Legal range |v| <= 31.
- LANE_INIT_X[0:5], {0,64,128,192,256,320}: log A x after reset or in MENU.

Ports:
- clk, in, 1: system clock.
- reset_n, in, 1: asynchronous active-low reset.
- state, in, 2: game state (MENU=0, PLAYING=1, DEAD=2, WIN=3).
- frame_tick, in, 1: one-cycle pulse, once per video frame.
- frog_x, in, 10: frog left x.
- frog_y, in, 10: frog top y.
- frog_size, in, 10: frog width in pixels.
- lane0_log_speed..lane5_log_speed, out, 10 signed each: per-frame dx pulse.
- in_lane0_log..in_lane5_log, out, 1 each: frog is riding a log in lane i.
- drowned, out, 1: frog is in a river lane but not on a log.
- log_x_flat, out, 60: log A x for each lane; lane i occupies bits [10i+9:10i].

Behaviour:
- Reset (reset_n=0, async): log_x[i]=LANE_INIT_X[i]. All speed outputs 0, all in_laneN_log 0, drowned 0.
- MENU: log_x held at LANE_INIT_X every cycle, so a new game starts aligned. DEAD/WIN: log_x frozen. In both, all speed, in_lane and drowned outputs are driven 0 (registered).
- Log advance: only on a cycle with state==PLAYING and frame_tick==1.
  - s = signed 11-bit log_x + LANE_SPEED.
  - If s >= SCREEN_W, log_x = s - SCREEN_W.
  - Else if s < 0, log_x = s + SCREEN_W.
  - Else log_x = s.
  - log_x is therefore always in 0..SCREEN_W-1.
- Speed pulse: laneN_log_speed is registered. It equals LANE_SPEED[N] for exactly the one cycle after the qualifying frame_tick, and is 0 otherwise. The frog adds dx every cycle it sees a nonzero value, so the pulse width must be exactly one cycle.
- Log occupancy:
  - Log A covers [log_x, log_x+LOG_LEN) modulo SCREEN_W.
  - Log B covers the same span starting at (log_x+LOG_GAP) mod SCREEN_W.
  - Wrap-around at the right edge counts as coverage.
- Riding test, registered every cycle (1-cycle latency from frog_x/frog_y):
  - cx = frog_x + frog_size/2 (floor).
  - d = (cx - log_x) mod SCREEN_W, computed in signed 11-bit with a single +SCREEN_W correction.
  - Frog is on log A if d < LOG_LEN; on log B if (d - LOG_GAP) mod SCREEN_W < LOG_LEN.
  - in_laneN_log = PLAYING && frog_y within lane N rows && (on A || on B).
  - At most one in_lane bit can be high, since the rows are disjoint.
- drowned (registered level): PLAYING && frog_y within [RIVER_TOP, RIVER_TOP+6*LANE_H) && no in_lane bit set in the same evaluation.
  - It stays high until the frog is reset upstream, which moves frog_y out of the river.
  - It is asserted on the first evaluation after the frog lands in water.
- The riding test uses log_x before any update in the same cycle. Its registered result and the speed pulse therefore both reflect pre-tick log positions in the same output cycle.
- If state leaves PLAYING on the same cycle as frame_tick: no move and no pulse.
- If reset_n is asserted mid-pulse: outputs clear immediately.
- All outputs are registered; no combinational paths from inputs to outputs.

Decomposition:
- Package frogger_pkg holds:
  - the game-state enum (MENU/PLAYING/DEAD/WIN);
  - SCREEN_W, SCREEN_H;
  - BLOCKSIZE=32;
  - NUM_LANES=6;
  - the log_len_t/coord_t typedefs.
  This package is shared with the frog controller and the renderer.
- Sub-module log_lane, instantiated 6 times, holds for one lane:
  - the position register and wrap adder;
  - the two-log coverage compare;
  - the row match;
  - the speed pulse register.
  The top level only ORs the per-lane results into drowned and flattens log_x.

Test Plan:
1. Reset, then state=MENU for 10 frame_ticks: log_x_flat lanes equal {0,64,128,192,256,320}; all speed outputs stay 0.
2. state=PLAYING, one frame_tick: next cycle lane0_log_speed=2 and lane1_log_speed=-3 for exactly one cycle. log_x lane0=2, lane1=61.
3. Wrap:
   - lane1 starting at 1, speed -3, one tick: log_x lane1=638.
   - lane4 starting at 638, speed +3, one tick: log_x lane4=1.
4. Riding:
   - frog_x=16, frog_y=64, frog_size=32 (cx=32), log_x lane0=0: in_lane0_log=1, drowned=0.
   - Set frog_x=100 (cx=116): in_lane0_log=0, drowned=1 one cycle later.
5. Log B and edge wrap:
   - lane2 log_x=600, frog_y=128, cx=20 (log A wraps over 600..695 mod 640): in_lane2_log=1.
   - cx=340 (log B spans 280..375): in_lane2_log=1.
6. frame_tick on the cycle state goes PLAYING->DEAD: no speed pulse, log_x unchanged, all in_lane/drowned 0 the next cycle.
   - Async reset_n low mid-PLAYING: outputs clear without a clock edge.
